// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
//   pipeline        : core-wide XLEN and the funct3 operation encoding used by
//                     the decoder, the ALU and this unit.
//   muldiv_unit_pkg : unit-local FSM state type, the signed-minimum constant
//                     and operand signedness helpers.
package pipeline;

    localparam int XLEN = 32;

    // Standard RISC-V M-extension funct3 encoding.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

endpackage

package muldiv_unit_pkg;

    import pipeline::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Most negative two's-complement value, MSB-aligned at the widest
    // supported XLEN; a narrower unit takes the top XLEN bits.
    localparam logic [63:0] SIGNED_MIN = 64'h8000_0000_0000_0000;

    // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op1_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV and REM.
    function automatic logic op2_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response channel between the integer pipeline and muldiv_unit.
//   master (core) : drives flush, in_valid, funct3, operand_1/2, out_ready
//   slave  (unit) : drives in_ready, out_valid, result, busy
interface muldiv_unit_if #(
    parameter int XLEN = pipeline::XLEN
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, funct3, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, funct3, operand_1, operand_2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit_iter.sv
// Radix-2 iterative datapath shared by multiply and divide.
//   load        : start a new operation from unsigned magnitudes mag_1/mag_2
//   run         : perform one iteration this cycle
//   is_div      : select restoring division instead of shift-add multiply
//   last        : the iteration about to execute is the final one
//   acc_hi/lo   : multiply -> {hi,lo} is the 2*XLEN product;
//                 divide   -> hi is the remainder, lo the quotient
module muldiv_iter #(
    parameter int XLEN = pipeline::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            run,
    input  logic            is_div,
    input  logic [XLEN-1:0] mag_1,
    input  logic [XLEN-1:0] mag_2,
    output logic            last,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] opb_r;     // multiplicand or divisor
    logic            is_div_r;
    logic [CW-1:0]   cnt_r;     // iterations remaining after the current one

    logic [XLEN:0]   add_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] hi_next_s;
    logic [XLEN-1:0] lo_next_s;

    // Next-iteration values for both algorithms.
    always_comb begin
        hi_next_s = hi_r;
        lo_next_s = lo_r;
        // Multiply: add multiplicand when multiplier LSB is set, then shift
        // the {carry, hi, lo} chain right so product bits enter lo from the top.
        add_s     = {1'b0, hi_r} + {1'b0, (lo_r[0] ? opb_r : {XLEN{1'b0}})};
        // Divide: shift the next dividend bit into the partial remainder and
        // try subtracting the divisor; bit XLEN set means it did not fit.
        trial_s   = {hi_r, lo_r[XLEN-1]} - {1'b0, opb_r};
        if (is_div_r) begin
            if (!trial_s[XLEN]) begin
                hi_next_s = trial_s[XLEN-1:0];
                lo_next_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_next_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
                lo_next_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next_s = add_s[XLEN:1];
            lo_next_s = {add_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Operand load and per-cycle iteration state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opb_r    <= {XLEN{1'b0}};
            is_div_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (load) begin
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= is_div ? mag_1 : mag_2;
            opb_r    <= is_div ? mag_2 : mag_1;
            is_div_r <= is_div;
            cnt_r    <= CW'(XLEN - 1);
        end else if (run) begin
            hi_r     <= hi_next_s;
            lo_r     <= lo_next_s;
            cnt_r    <= cnt_r - CW'(1);
        end
    end

    assign last   = (cnt_r == {CW{1'b0}});
    assign acc_hi = hi_r;
    assign acc_lo = lo_r;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : muldiv_unit_if slave - valid/ready request (funct3, operands),
//                valid/ready response (result), flush and busy
// Holds the control FSM, operand sign handling, special-case detection and
// the final sign correction; muldiv_iter does the per-bit work.
module muldiv_unit
    import pipeline::*;
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = pipeline::XLEN
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_unit_if.slave   bus
);
    localparam logic [XLEN-1:0] MIN_NEG = SIGNED_MIN[63 -: XLEN];
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

    muldiv_state_e   state_r;
    muldiv_op_e      op_r;
    logic            neg_r;        // final value must be negated
    logic [XLEN-1:0] result_r;
    logic            out_valid_r;

    muldiv_op_e      op_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            neg_1_s;
    logic            neg_2_s;
    logic [XLEN-1:0] mag_1_s;
    logic [XLEN-1:0] mag_2_s;
    logic            div_zero_s;
    logic            overflow_s;
    logic            special_s;
    logic [XLEN-1:0] special_res_s;
    logic            neg_s;

    logic            last_s;
    logic [XLEN-1:0] acc_hi_s;
    logic [XLEN-1:0] acc_lo_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0] quot_fix_s;
    logic [XLEN-1:0] rem_fix_s;
    logic [XLEN-1:0] fix_res_s;

    // A request in the same cycle as flush is refused.
    assign in_ready_s = (state_r == ST_IDLE) && !bus.flush;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Decode of the incoming request: magnitudes, result sign, special cases.
    always_comb begin
        op_s       = muldiv_op_e'(bus.funct3);
        neg_1_s    = op1_is_signed(op_s) && bus.operand_1[XLEN-1];
        neg_2_s    = op2_is_signed(op_s) && bus.operand_2[XLEN-1];
        mag_1_s    = neg_1_s ? (ZERO - bus.operand_1) : bus.operand_1;
        mag_2_s    = neg_2_s ? (ZERO - bus.operand_2) : bus.operand_2;
        div_zero_s = bus.funct3[2] && (bus.operand_2 == ZERO);
        overflow_s = ((op_s == OP_DIV) || (op_s == OP_REM)) &&
                     (bus.operand_1 == MIN_NEG) && (bus.operand_2 == ALL_ONES);
        special_s  = div_zero_s || overflow_s;
        // Remainder follows the dividend sign; products and quotients are
        // negative when exactly one operand is.
        case (op_s)
            OP_MULH, OP_MULHSU, OP_DIV: neg_s = neg_1_s ^ neg_2_s;
            OP_REM:                     neg_s = neg_1_s;
            default:                    neg_s = 1'b0;
        endcase
        // Overflow: quotient is the dividend itself and the remainder zero.
        case (op_s)
            OP_DIV:  special_res_s = div_zero_s ? ALL_ONES : bus.operand_1;
            OP_DIVU: special_res_s = ALL_ONES;
            OP_REM:  special_res_s = div_zero_s ? bus.operand_1 : ZERO;
            OP_REMU: special_res_s = bus.operand_1;
            default: special_res_s = ZERO;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept_s && !special_s),
        .run    ((state_r == ST_CALC) && !bus.flush),
        .is_div (bus.funct3[2]),
        .mag_1  (mag_1_s),
        .mag_2  (mag_2_s),
        .last   (last_s),
        .acc_hi (acc_hi_s),
        .acc_lo (acc_lo_s)
    );

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod_fix_s = neg_r ? ({(2*XLEN){1'b0}} - {acc_hi_s, acc_lo_s}) : {acc_hi_s, acc_lo_s};
        quot_fix_s = neg_r ? (ZERO - acc_lo_s) : acc_lo_s;
        rem_fix_s  = neg_r ? (ZERO - acc_hi_s) : acc_hi_s;
        case (op_r)
            OP_MUL:                       fix_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = quot_fix_s;
            OP_REM, OP_REMU:              fix_res_s = rem_fix_s;
            default:                      fix_res_s = ZERO;
        endcase
    end

    // Control FSM with registered result and out_valid; flush wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_MUL;
            neg_r       <= 1'b0;
            result_r    <= ZERO;
            out_valid_r <= 1'b0;
        end else if (bus.flush) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r  <= op_s;
                        neg_r <= neg_s;
                        if (special_s) begin
                            result_r    <= special_res_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r     <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (last_s) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_r    <= fix_res_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.busy      = (state_r != ST_IDLE);

endmodule
